// File: rtl/interrupt_sequencer.sv
// 6502 interrupt entry sequencer: arbitrates RESET/NMI/IRQ/BRK and steps the
// seven-cycle stack-push / vector-fetch sequence, producing bus and P strobes.
module interrupt_sequencer #(
    parameter logic [15:0] VEC_NMI   = 16'hFFFA,
    parameter logic [15:0] VEC_RESET = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ   = 16'hFFFE
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rdy,
    input  logic        i_sync,
    input  logic        i_brk,
    input  logic        i_nmi_n,
    input  logic        i_irq_n,
    input  logic        i_p_i,
    output logic        o_force_brk,
    output logic        o_active,
    output logic        o_stack_wr,
    output logic        o_push_pch,
    output logic        o_push_pcl,
    output logic        o_push_p,
    output logic        o_b_push,
    output logic        o_ir5_i,
    output logic        o_vec_lo,
    output logic        o_vec_hi,
    output logic [15:0] o_vector,
    output logic [1:0]  o_src
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        T6   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_BRK   = 2'd0,
        SRC_IRQ   = 2'd1,
        SRC_NMI   = 2'd2,
        SRC_RESET = 2'd3
    } src_t;

    state_t      state_q, state_d;
    src_t        src_q, src_d;
    logic [15:0] vector_q, vector_d;
    logic        nmi_prev_q, nmi_prev_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        active_q, active_d;
    logic        stack_wr_q, stack_wr_d;
    logic        push_pch_q, push_pch_d;
    logic        push_pcl_q, push_pcl_d;
    logic        push_p_q, push_p_d;
    logic        b_push_q, b_push_d;
    logic        ir5_i_q, ir5_i_d;
    logic        vec_lo_q, vec_lo_d;
    logic        vec_hi_q, vec_hi_d;

    logic        nmi_edge;
    logic        nmi_clear;
    logic        hw_req;

    always_comb begin
        nmi_edge    = nmi_prev_q & ~i_nmi_n;
        hw_req      = nmi_pend_q | (~i_irq_n & ~i_p_i);
        o_force_brk = i_sync & hw_req;
        nmi_prev_d  = i_nmi_n;

        state_d = state_q;
        src_d   = src_q;
        if (i_rdy) begin
            case (state_q)
                IDLE: begin
                    if (i_sync) begin
                        if (hw_req) begin
                            state_d = T1;
                            src_d   = nmi_pend_q ? SRC_NMI : SRC_IRQ;
                        end else if (i_brk) begin
                            state_d = T1;
                            src_d   = SRC_BRK;
                        end
                    end
                end
                T1: state_d = T2;
                T2: state_d = T3;
                T3: state_d = T4;
                T4: begin
                    // B has already gone out with P, so an NMI can still steal the vector here
                    state_d = T5;
                    if (nmi_pend_q && (src_q == SRC_BRK || src_q == SRC_IRQ))
                        src_d = SRC_NMI;
                end
                T5:      state_d = T6;
                T6:      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        nmi_clear  = (state_q == T4) && (state_d == T5) && (src_d == SRC_NMI);
        nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clear);

        case (src_d)
            SRC_NMI:   vector_d = VEC_NMI;
            SRC_RESET: vector_d = VEC_RESET;
            default:   vector_d = VEC_IRQ;
        endcase

        // Strobes are decoded from the next state so they line up with state_q
        active_d   = (state_d != IDLE);
        stack_wr_d = (src_d != SRC_RESET) &&
                     (state_d == T2 || state_d == T3 || state_d == T4);
        push_pch_d = (state_d == T2);
        push_pcl_d = (state_d == T3);
        push_p_d   = (state_d == T4);
        b_push_d   = (state_d == T4) && (src_d == SRC_BRK);
        ir5_i_d    = (state_d == T5);
        vec_lo_d   = (state_d == T5);
        vec_hi_d   = (state_d == T6);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= T1;
            src_q      <= SRC_RESET;
            vector_q   <= VEC_RESET;
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            active_q   <= 1'b1;
            stack_wr_q <= 1'b0;
            push_pch_q <= 1'b0;
            push_pcl_q <= 1'b0;
            push_p_q   <= 1'b0;
            b_push_q   <= 1'b0;
            ir5_i_q    <= 1'b0;
            vec_lo_q   <= 1'b0;
            vec_hi_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            vector_q   <= vector_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
            active_q   <= active_d;
            stack_wr_q <= stack_wr_d;
            push_pch_q <= push_pch_d;
            push_pcl_q <= push_pcl_d;
            push_p_q   <= push_p_d;
            b_push_q   <= b_push_d;
            ir5_i_q    <= ir5_i_d;
            vec_lo_q   <= vec_lo_d;
            vec_hi_q   <= vec_hi_d;
        end
    end

    assign o_active   = active_q;
    assign o_stack_wr = stack_wr_q;
    assign o_push_pch = push_pch_q;
    assign o_push_pcl = push_pcl_q;
    assign o_push_p   = push_p_q;
    assign o_b_push   = b_push_q;
    assign o_ir5_i    = ir5_i_q;
    assign o_vec_lo   = vec_lo_q;
    assign o_vec_hi   = vec_hi_q;
    assign o_vector   = vector_q;
    assign o_src      = src_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: reset entry, IRQ, BRK, NMI hijack,
// NMI capture under i_rdy=0, i_rdy stalls and reset abort.
module tb_interrupt_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset, i_rdy, i_sync, i_brk, i_nmi_n, i_irq_n, i_p_i;
    logic        o_force_brk, o_active, o_stack_wr, o_push_pch, o_push_pcl;
    logic        o_push_p, o_b_push, o_ir5_i, o_vec_lo, o_vec_hi;
    logic [15:0] o_vector;
    logic [1:0]  o_src;

    int n_checks = 0;
    int n_fail   = 0;

    // {active, stack_wr, pch, pcl, p, b_push, ir5_i, vec_lo, vec_hi}
    logic [8:0] strobes;
    assign strobes = {o_active, o_stack_wr, o_push_pch, o_push_pcl, o_push_p,
                      o_b_push, o_ir5_i, o_vec_lo, o_vec_hi};

    localparam logic [8:0] S_IDLE  = 9'b000000000;
    localparam logic [8:0] S_T1    = 9'b100000000;
    localparam logic [8:0] S_R_T2  = 9'b101000000;
    localparam logic [8:0] S_R_T3  = 9'b100100000;
    localparam logic [8:0] S_R_T4  = 9'b100010000;
    localparam logic [8:0] S_W_T2  = 9'b111000000;
    localparam logic [8:0] S_W_T3  = 9'b110100000;
    localparam logic [8:0] S_W_T4  = 9'b110010000;
    localparam logic [8:0] S_BK_T4 = 9'b110011000;
    localparam logic [8:0] S_T5    = 9'b100000110;
    localparam logic [8:0] S_T6    = 9'b100000001;

    interrupt_sequencer dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rdy       (i_rdy),
        .i_sync      (i_sync),
        .i_brk       (i_brk),
        .i_nmi_n     (i_nmi_n),
        .i_irq_n     (i_irq_n),
        .i_p_i       (i_p_i),
        .o_force_brk (o_force_brk),
        .o_active    (o_active),
        .o_stack_wr  (o_stack_wr),
        .o_push_pch  (o_push_pch),
        .o_push_pcl  (o_push_pcl),
        .o_push_p    (o_push_p),
        .o_b_push    (o_b_push),
        .o_ir5_i     (o_ir5_i),
        .o_vec_lo    (o_vec_lo),
        .o_vec_hi    (o_vec_hi),
        .o_vector    (o_vector),
        .o_src       (o_src)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Step from T1 through T6 back to IDLE, checking each state's strobes
    task automatic runTail(input string tag, input logic [8:0] t2, input logic [8:0] t3,
                           input logic [8:0] t4, input logic [15:0] vec, input logic [1:0] src);
        tick(); checkOutput({tag, " T2"}, 32'(strobes), 32'(t2));
        tick(); checkOutput({tag, " T3"}, 32'(strobes), 32'(t3));
        tick(); checkOutput({tag, " T4"}, 32'(strobes), 32'(t4));
        tick(); checkOutput({tag, " T5"}, 32'(strobes), 32'(S_T5));
        checkOutput({tag, " T5 vector"}, 32'(o_vector), 32'(vec));
        checkOutput({tag, " T5 src"}, 32'(o_src), 32'(src));
        tick(); checkOutput({tag, " T6"}, 32'(strobes), 32'(S_T6));
        checkOutput({tag, " T6 vector"}, 32'(o_vector), 32'(vec));
        tick(); checkOutput({tag, " idle"}, 32'(strobes), 32'(S_IDLE));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        i_reset = 1'b1; i_rdy = 1'b1; i_sync = 1'b0; i_brk = 1'b0;
        i_nmi_n = 1'b1; i_irq_n = 1'b1; i_p_i = 1'b0;
        repeat (3) tick();
        checkOutput("reset strobes", 32'(strobes), 32'(S_T1));
        checkOutput("reset src", 32'(o_src), 32'd3);
        checkOutput("reset vector", 32'(o_vector), 32'hFFFC);

        // Reset release: six-cycle sequence with dummy stack reads
        i_reset = 1'b0;
        runTail("rst", S_R_T2, S_R_T3, S_R_T4, 16'hFFFC, 2'd3);

        // IRQ with I clear is taken at the sync cycle
        i_sync = 1'b1; i_irq_n = 1'b0; i_p_i = 1'b0;
        #1 checkOutput("irq force_brk", 32'(o_force_brk), 32'd1);
        tick();
        i_sync = 1'b0; i_irq_n = 1'b1;
        checkOutput("irq T1", 32'(strobes), 32'(S_T1));
        checkOutput("irq src", 32'(o_src), 32'd1);
        runTail("irq", S_W_T2, S_W_T3, S_W_T4, 16'hFFFE, 2'd1);

        // IRQ masked by I: nothing starts
        i_sync = 1'b1; i_irq_n = 1'b0; i_p_i = 1'b1;
        #1 checkOutput("masked force_brk", 32'(o_force_brk), 32'd0);
        tick();
        checkOutput("masked idle", 32'(strobes), 32'(S_IDLE));

        // BRK while the masked IRQ is still low
        i_brk = 1'b1;
        tick();
        i_sync = 1'b0; i_brk = 1'b0; i_irq_n = 1'b1; i_p_i = 1'b0;
        checkOutput("brk src", 32'(o_src), 32'd0);
        runTail("brk", S_W_T2, S_W_T3, S_BK_T4, 16'hFFFE, 2'd0);

        // BRK hijacked by an NMI edge arriving in T3
        i_sync = 1'b1; i_brk = 1'b1;
        tick();
        i_sync = 1'b0; i_brk = 1'b0;
        tick(); checkOutput("hijack T2", 32'(strobes), 32'(S_W_T2));
        tick(); checkOutput("hijack T3", 32'(strobes), 32'(S_W_T3));
        i_nmi_n = 1'b0;
        tick(); checkOutput("hijack T4", 32'(strobes), 32'(S_BK_T4));
        checkOutput("hijack T4 src", 32'(o_src), 32'd0);
        tick(); checkOutput("hijack T5", 32'(strobes), 32'(S_T5));
        checkOutput("hijack T5 src", 32'(o_src), 32'd2);
        checkOutput("hijack T5 vector", 32'(o_vector), 32'hFFFA);
        tick(); checkOutput("hijack T6 vector", 32'(o_vector), 32'hFFFA);
        tick(); checkOutput("hijack idle", 32'(strobes), 32'(S_IDLE));
        i_sync = 1'b1;
        #1 checkOutput("hijack pend cleared", 32'(o_force_brk), 32'd0);
        tick();
        checkOutput("hijack no retrigger", 32'(strobes), 32'(S_IDLE));
        i_sync = 1'b0; i_nmi_n = 1'b1;
        tick();

        // NMI edge captured while i_rdy is low in IDLE
        i_rdy = 1'b0; i_nmi_n = 1'b0;
        tick(); tick();
        checkOutput("nmi rdy0 idle", 32'(strobes), 32'(S_IDLE));
        i_rdy = 1'b1; i_sync = 1'b1;
        #1 checkOutput("nmi force_brk", 32'(o_force_brk), 32'd1);
        tick();
        i_sync = 1'b0;
        checkOutput("nmi src", 32'(o_src), 32'd2);
        runTail("nmi", S_W_T2, S_W_T3, S_W_T4, 16'hFFFA, 2'd2);
        i_sync = 1'b1;
        #1 checkOutput("nmi held low no retrigger", 32'(o_force_brk), 32'd0);
        tick();
        checkOutput("nmi held low idle", 32'(strobes), 32'(S_IDLE));
        i_sync = 1'b0; i_nmi_n = 1'b1;

        // i_rdy stall in T3, then reset abort in T4
        i_sync = 1'b1; i_irq_n = 1'b0;
        tick();
        i_sync = 1'b0; i_irq_n = 1'b1;
        tick(); tick();
        checkOutput("stall T3", 32'(strobes), 32'(S_W_T3));
        i_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall hold %0d", i), 32'(strobes), 32'(S_W_T3));
        end
        i_rdy = 1'b1;
        tick(); checkOutput("stall T4", 32'(strobes), 32'(S_W_T4));
        i_reset = 1'b1;
        tick();
        checkOutput("abort strobes", 32'(strobes), 32'(S_T1));
        checkOutput("abort src", 32'(o_src), 32'd3);
        checkOutput("abort vector", 32'(o_vector), 32'hFFFC);
        i_reset = 1'b0;
        runTail("abort", S_R_T2, S_R_T3, S_R_T4, 16'hFFFC, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
